// File: rtl/syscall_resp.sv
// Syscall responder: queues {num, op1} requests and services them on an 8N1 console line.
// Optional SYSCALL_RESP_CRLF_EN: putchar of LF is expanded to CR, LF.
module syscall_resp #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_num,
    input  logic [31:0] i_op1,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_halted,
    output logic [31:0] o_exit_code,
    output logic [7:0]  o_bad_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE = BW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, HALT} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push;
    logic [31:0]   num_r, op_r;
    logic [7:0]    ch;
    logic [2:0]    nib, nib_nx, bit_cnt;
    logic [BW-1:0] baud;
`ifdef SYSCALL_RESP_CRLF_EN
    logic          lf_pend;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_ready = !full && !o_halted;
    assign push    = i_valid && o_ready;
    assign o_busy  = !empty || (state != IDLE);
    assign nib_nx  = nib - 3'd1;

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {i_num, i_op1};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            num_r       <= '0;
            op_r        <= '0;
            ch          <= '0;
            nib         <= '0;
            bit_cnt     <= '0;
            baud        <= '0;
            o_tx        <= 1'b1;
            o_halted    <= 1'b0;
            o_exit_code <= '0;
            o_bad_cnt   <= '0;
`ifdef SYSCALL_RESP_CRLF_EN
            lf_pend     <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {num_r, op_r} <= mem[rd_ptr[AW-1:0]];
                        rd_ptr        <= rd_ptr + PTR_ONE;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    if (num_r == 32'd1) begin
`ifdef SYSCALL_RESP_CRLF_EN
                        if (op_r[7:0] == 8'h0A) begin
                            ch      <= 8'h0D;
                            lf_pend <= 1'b1;
                        end else begin
                            ch <= op_r[7:0];
                        end
`else
                        ch <= op_r[7:0];
`endif
                        o_tx  <= 1'b0;
                        state <= START;
                    end else if (num_r == 32'd2) begin
                        nib   <= 3'd7;
                        ch    <= hex_char(op_r[31:28]);
                        o_tx  <= 1'b0;
                        state <= START;
                    end else if (num_r == 32'd3) begin
                        o_exit_code <= op_r;
                        o_halted    <= 1'b1;
                        state       <= HALT;
                    end else begin
                        if (o_bad_cnt != 8'hFF) o_bad_cnt <= o_bad_cnt + 8'd1;
                        state <= IDLE;
                    end
                end
                START: begin
                    if (baud == BAUD_MAX) begin
                        baud  <= '0;
                        o_tx  <= ch[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud == BAUD_MAX) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            o_tx  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            o_tx    <= ch[1];
                            ch      <= {1'b0, ch[7:1]};
                        end
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud == BAUD_MAX) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        // Chained frames go straight back to START with no idle gap.
`ifdef SYSCALL_RESP_CRLF_EN
                        if (lf_pend) begin
                            lf_pend <= 1'b0;
                            ch      <= 8'h0A;
                            o_tx    <= 1'b0;
                            state   <= START;
                        end else if (num_r == 32'd2 && nib != 3'd0) begin
                            nib   <= nib_nx;
                            ch    <= hex_char(op_r[{nib_nx, 2'b00} +: 4]);
                            o_tx  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
`else
                        if (num_r == 32'd2 && nib != 3'd0) begin
                            nib   <= nib_nx;
                            ch    <= hex_char(op_r[{nib_nx, 2'b00} +: 4]);
                            o_tx  <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
`endif
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                HALT: begin
                    o_tx   <= 1'b1;
                    rd_ptr <= wr_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_resp.sv
// Self-checking bench for syscall_resp: directed timing checks plus randomized requests
// compared against a byte-stream model; a line monitor decodes 8N1 frames.
module tb_syscall_resp;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_num, i_op1;
    logic        o_ready, o_tx, o_busy, o_halted;
    logic [31:0] o_exit_code;
    logic [7:0]  o_bad_cnt;

    syscall_resp #(.DEPTH(DEP), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_num(i_num), .i_op1(i_op1),
        .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_halted(o_halted),
        .o_exit_code(o_exit_code), .o_bad_cnt(o_bad_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total = 0, passed = 0, frame_err = 0, last_acc = 0;
    logic [7:0]  rx_q[$], exp_q[$];
    int unsigned start_q[$];
    int          m_bad = 0;
    bit          m_halted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: expected console bytes derived directly from the syscall rules.
    task automatic model_req(input logic [31:0] num, input logic [31:0] op);
        string hx = "0123456789abcdef";
        logic [3:0] nb;
        if (m_halted) return;
        if (num == 32'd1) begin
`ifdef SYSCALL_RESP_CRLF_EN
            if (op[7:0] == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(op[7:0]);
        end else if (num == 32'd2) begin
            for (int i = 7; i >= 0; i--) begin
                nb = 4'((op >> (4 * i)) & 32'hF);
                exp_q.push_back(8'(hx[int'(nb)]));
            end
        end else if (num == 32'd3) begin
            m_halted = 1;
        end else if (m_bad < 255) begin
            m_bad++;
        end
    endtask

    // 8N1 decoder: samples each bit in its middle.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (o_tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = o_tx;
                end
                repeat (CPB) @(negedge clk);
                if (o_tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] num, input logic [31:0] op);
        int n = 0;
        i_valid = 1'b1; i_num = num; i_op1 = op;
        while (o_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        check("send_timeout", {31'b0, n >= 5000}, 32'd0);
        @(negedge clk);
        last_acc = cyc;
        i_valid = 1'b0;
        if (n < 5000) model_req(num, op);
    endtask

    task automatic compare_rx(input string tag, input bit wait_idle);
        int n = 0;
        if (wait_idle) begin
            while (o_busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
            check({tag, "_idle_timeout"}, {31'b0, n >= 20000}, 32'd0);
        end
        repeat (3 * CPB) @(negedge clk);
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
        rx_q.delete(); exp_q.delete(); start_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); m_bad = 0; m_halted = 0;
        repeat (12 * CPB) @(negedge clk);
        rx_q.delete(); start_q.delete();
    endtask

    int          offs[8]  = '{-1, 0, 3, 4, 8, 28, 32, 36};
    logic        txexp[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int unsigned s, n;
    logic [31:0] num, op;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_num = '0; i_op1 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, o_tx}, 32'd1);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_halted", {31'b0, o_halted}, 32'd0);
        check("rst_exit", o_exit_code, 32'd0);
        check("rst_bad", {24'b0, o_bad_cnt}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // putchar 0x41: exact line waveform and busy timing
        send(32'd1, 32'h41);
        s = last_acc + 2;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(s + offs[i]);
            check("A_tx_wave", {31'b0, o_tx}, {31'b0, txexp[i]});
        end
        n = 0;
        while (o_busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        check("A_busy_clear_cyc", cyc, s + 40);
        check("A_bad", {24'b0, o_bad_cnt}, 32'd0);
        compare_rx("A", 1);

        // puthex: 8 frames, back to back
        send(32'd2, 32'h00C0FFEE);
        compare_rx("hex_pre", 1);
        send(32'd2, 32'h00C0FFEE);
        while (o_busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        repeat (3 * CPB) @(negedge clk);
        check("hex_frames", start_q.size(), 32'd8);
        for (int i = 1; i < start_q.size(); i++)
            check("hex_gap", start_q[i] - start_q[i-1], 10 * CPB);
        compare_rx("hex", 0);

        // six back-to-back putchars against a depth-4 queue
        for (int i = 0; i < 6; i++) begin
            send(32'd1, 32'($urandom_range(8'h20, 8'h7E)));
            if (i == 0) s = last_acc;
            if (i == 4) check("bp_ready_low", {31'b0, o_ready}, 32'd0);
        end
        check("bp_sixth_acc", last_acc, s + 44);
        compare_rx("bp", 1);

        // putchar 'x', exit 7, then a putchar that must be discarded
        send(32'd1, 32'h78);
        s = last_acc + 2;
        send(32'd3, 32'd7);
        send(32'd1, 32'h79);
        n = 0;
        while (o_halted !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        check("halt_cyc", cyc, s + 42);
        check("halt_exit", o_exit_code, 32'd7);
        check("halt_ready", {31'b0, o_ready}, 32'd0);
        repeat (100) @(negedge clk);
        check("halt_tx", {31'b0, o_tx}, 32'd1);
        check("halt_exit_hold", o_exit_code, 32'd7);
        compare_rx("halt", 0);
        do_reset();

        // unknown syscalls and saturation
        send(32'd9, $urandom);
        repeat (60) @(negedge clk);
        check("bad_one", {24'b0, o_bad_cnt}, 32'd1);
        check("bad_no_frames", start_q.size(), 32'd0);
        for (int i = 0; i < 256; i++) begin
            num = $urandom;
            if (num >= 32'd1 && num <= 32'd3) num = num + 32'd16;
            send(num, $urandom);
        end
        compare_rx("bad_sat", 1);
        check("bad_sat_model", {24'b0, o_bad_cnt}, 32'(m_bad));
        check("bad_sat_255", {24'b0, o_bad_cnt}, 32'd255);
        do_reset();

        // randomized mix of putchar, puthex and unknown numbers
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    num = 32'd1;
                2:       num = 32'd2;
                default: num = 32'd7;
            endcase
            op = $urandom;
            if (num == 32'd1 && $urandom_range(0, 3) == 0) op[7:0] = 8'h0A;
            send(num, op);
        end
        compare_rx("rand", 1);
        check("rand_bad", {24'b0, o_bad_cnt}, 32'(m_bad));

        // reset in the middle of a puthex data phase
        send(32'd2, $urandom);
        wait_cyc(last_acc + 2 + 3 * CPB);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx", {31'b0, o_tx}, 32'd1);
        check("mid_rst_busy", {31'b0, o_busy}, 32'd0);
        check("mid_rst_bad", {24'b0, o_bad_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); m_bad = 0; m_halted = 0;
        repeat (12 * CPB) @(negedge clk);
        rx_q.delete(); start_q.delete();
        send(32'd1, 32'h55);
        compare_rx("post_rst", 1);

        // line feed (expanded to CR LF when the option is built in)
        send(32'd1, 32'h0A);
        while (o_busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
        repeat (3 * CPB) @(negedge clk);
        for (int i = 1; i < start_q.size(); i++)
            check("lf_gap", start_q[i] - start_q[i-1], 10 * CPB);
        compare_rx("lf", 0);

        check("frame_errors", frame_err, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/syscall_resp.md
Name: syscall_resp

Overview:
- Responder end of the core's syscall path: accepts syscall requests (number plus operand) from the processor and services them.
- Requests queue in a small FIFO. A serial engine drains them in order, emitting console bytes on an 8N1 line.
- An exit syscall halts the block and latches an exit code.
- Provides backpressure (o_ready) so the core can stall when the queue is full.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2.
- CLKS_PER_BIT, 4, clock cycles per serial bit; >=1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  request present this cycle.
- i_num  in  32  syscall number.
- i_op1  in  32  syscall operand.
- o_ready  out  1  request accepted on an edge where i_valid & o_ready.
- o_tx  out  1  serial console line; idles high.
- o_busy  out  1  FIFO non-empty or engine not IDLE.
- o_halted  out  1  exit syscall executed.
- o_exit_code  out  32  operand of the exit syscall.
- o_bad_cnt  out  8  count of unknown syscall numbers.

Behaviour:
- Reset (async, immediate):
  - o_tx=1, o_ready=1, o_busy=0, o_halted=0, o_exit_code=0, o_bad_cnt=0.
  - FIFO emptied; engine to IDLE.
  - Reset mid-frame aborts the frame; o_tx goes high at once.
- FIFO:
  - Entry = {num, op1}.
  - o_ready = !full & !o_halted (combinational).
  - A push when full is impossible because o_ready=0; a pop in the same cycle does not re-enable o_ready.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Syscall numbers:
  - 1 putchar: send op1[7:0].
  - 2 puthex: send 8 ASCII chars of op1, most-significant nibble first, using '0'-'9' and 'a'-'f'.
  - 3 exit: halt.
  - Any other number: dropped, o_bad_cnt+1, saturating at 255.
- Engine states: IDLE, LOAD, START, DATA, STOP, HALT.
  - IDLE: if FIFO non-empty, pop the head into a working register and go to LOAD.
  - LOAD:
    - num=1: set char and go to START.
    - num=2: set nibble index 7, char = hex(op1[31:28]), go to START.
    - num=3: o_exit_code<=op1, o_halted<=1, go to HALT.
    - other: bump o_bad_cnt, go to IDLE.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit counter and a baud counter.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then, if puthex with nibbles remaining, decrement the index, load the next char and go to START (no idle gap); otherwise go to IDLE.
  - HALT: terminal until reset. Remaining FIFO entries are discarded (FIFO cleared on entry); o_tx=1.
- Latency:
  - Request accepted at edge N with FIFO empty and engine IDLE: pop at edge N+1, START at edge N+2, so o_tx falls at edge N+2.
  - Frame length = 10*CLKS_PER_BIT cycles.
  - Back-to-back putchars: next START begins 2 cycles after STOP ends (IDLE, LOAD).
- Ordering: strictly FIFO. An exit takes effect only after all earlier requests have finished transmitting.
- o_exit_code holds its value after halt.

Optional Feature:
- Macro: SYSCALL_RESP_CRLF_EN.
- Defined: putchar of 0x0A emits 0x0D then 0x0A as two consecutive frames, with no IDLE gap between them. Puthex output is unaffected.
- Undefined: 0x0A is sent as a single frame.

Test Plan:
- putchar 0x41, CLKS_PER_BIT=4, accepted at edge N:
  - o_tx low for cycles N+2..N+5.
  - Data bits 1,0,0,0,0,0,1,0, four cycles each.
  - Stop high.
  - o_busy clears 40 cycles after START; o_bad_cnt=0.
- puthex 0x00C0FFEE -> 8 frames, bytes 0x30,0x30,0x63,0x30,0x66,0x66,0x65,0x65, each STOP immediately followed by START.
- DEPTH=4, 6 putchars issued back-to-back while the first is transmitting:
  - o_ready=0 once 4 entries are queued, returns to 1 after the next pop.
  - All 6 bytes come out in order.
- putchar 'x' then exit 7:
  - o_halted rises only after the 'x' STOP phase; o_exit_code=7.
  - o_ready=0 afterwards.
  - A putchar queued after the exit is never transmitted.
- num=9 -> no o_tx activity, o_bad_cnt=1. 256 unknown requests -> o_bad_cnt holds 255.
- Reset mid-DATA of a puthex:
  - o_tx=1 and o_busy=0 immediately.
  - After release, putchar 0x55 is sent cleanly.
  - With SYSCALL_RESP_CRLF_EN defined, putchar 0x0A yields frames 0x0D, 0x0A.
